// File: rtl/display_mux_7seg.sv
// display_mux_7seg
//   Time-multiplexed N-digit 7-segment driver for the Hamming decoder outputs.
//   Each digit carries a 5-bit code: 0x00-0x0F corrected hex nibble, 0x10 double
//   error (shown as a dash), 0x11-0x1F blank. Codes are held in shadow registers
//   that load together, so a scan never shows a partial update.
//
//   Ports
//     clk, rst      clock (rising edge), synchronous active-high reset
//     data_in       5*N_DIGITS digit codes, digit i = data_in[5*i+:5]
//     load          1-cycle strobe, captures data_in into the shadow registers
//     blink_en      blink digits holding code 0x10
//     lz_blank_en   blank leading zeros (digit 0 always lit)
//     seven         segments a..g ([6]=a, [0]=g), active-low, registered
//     anodo         digit enables, active-low, at most one low, registered
//     digit_idx     slot currently being scanned
//
//   The scan/blink counters and the output registers are updated on the same
//   edge, and the outputs are built from the counters' next values. That keeps
//   the dead-time slot exactly aligned with refresh count 0. Segment data comes
//   from the current shadow registers, so a freshly loaded code appears one
//   cycle after its capture edge.

// Per-digit segment generation: decode plus the two blanking overrides.
module display_mux_7seg_digit (
  input  logic [4:0] code,
  input  logic       lz_blank,   // leading-zero blank for this digit
  input  logic       blink_off,  // blink phase is currently "off"
  output logic [6:0] seg
);
  logic [6:0] raw;

  always_comb begin
    case (code)
      5'h00:   raw = 7'b0000001;
      5'h01:   raw = 7'b1001111;
      5'h02:   raw = 7'b0010010;
      5'h03:   raw = 7'b0000110;
      5'h04:   raw = 7'b1001100;
      5'h05:   raw = 7'b0100100;
      5'h06:   raw = 7'b0100000;
      5'h07:   raw = 7'b0001111;
      5'h08:   raw = 7'b0000000;
      5'h09:   raw = 7'b0000100;
      5'h0A:   raw = 7'b0001000;
      5'h0B:   raw = 7'b1100000;
      5'h0C:   raw = 7'b0110001;
      5'h0D:   raw = 7'b1000010;
      5'h0E:   raw = 7'b0110000;
      5'h0F:   raw = 7'b0111000;
      5'h10:   raw = 7'b1111110;
      default: raw = 7'b1111111;
    endcase
  end

  always_comb begin
    seg = raw;
    if (lz_blank)
      seg = 7'b1111111;
    else if (blink_off && code == 5'h10)
      seg = 7'b1111111;
  end
endmodule

module display_mux_7seg #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25_000_000,
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5*N_DIGITS-1:0]   data_in,
  input  logic                    load,
  input  logic                    blink_en,
  input  logic                    lz_blank_en,
  output logic [6:0]              seven,
  output logic [N_DIGITS-1:0]     anodo,
  output logic [IW-1:0]           digit_idx
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [N_DIGITS-1:0][4:0] shadow;
  logic [RW-1:0]            rcnt, rcnt_nxt;
  logic [IW-1:0]            idx_nxt;
  logic [BW-1:0]            bcnt, bcnt_nxt;
  logic                     phase, phase_nxt;

  logic [N_DIGITS-1:0][6:0] dseg;      // final segments per digit
  logic [N_DIGITS-1:0]      zero_up;   // digits N-1..k all hold 0x00
  logic [N_DIGITS-1:0]      lz_blank;

  // Next-state of the scan and blink timers.
  always_comb begin
    rcnt_nxt = rcnt + RW'(1);
    idx_nxt  = digit_idx;
    if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt_nxt = '0;
      idx_nxt  = (digit_idx == IW'(N_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
    end
    bcnt_nxt  = bcnt + BW'(1);
    phase_nxt = phase;
    if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt_nxt  = '0;
      phase_nxt = ~phase;
    end
  end

  // Leading-zero detection runs from the most significant digit downward.
  genvar k;
  generate
    for (k = 0; k < N_DIGITS; k++) begin : g_dig
      if (k == N_DIGITS - 1) begin : g_top
        assign zero_up[k] = (shadow[k] == 5'h00);
      end else begin : g_low
        assign zero_up[k] = (shadow[k] == 5'h00) && zero_up[k+1];
      end

      if (k == 0) begin : g_d0
        assign lz_blank[k] = 1'b0;
      end else begin : g_dn
        assign lz_blank[k] = lz_blank_en && zero_up[k];
      end

      display_mux_7seg_digit u_digit (
        .code      (shadow[k]),
        .lz_blank  (lz_blank[k]),
        .blink_off (blink_en && phase_nxt),
        .seg       (dseg[k])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= {N_DIGITS{5'h1F}};
      rcnt      <= '0;
      digit_idx <= '0;
      bcnt      <= '0;
      phase     <= 1'b0;
      seven     <= 7'b1111111;
      anodo     <= '1;
    end else begin
      if (load)
        shadow <= data_in;
      rcnt      <= rcnt_nxt;
      digit_idx <= idx_nxt;
      bcnt      <= bcnt_nxt;
      phase     <= phase_nxt;
      // Slot start is dark to avoid ghosting while the anode switches.
      if (rcnt_nxt == '0) begin
        seven <= 7'b1111111;
        anodo <= '1;
      end else begin
        seven <= dseg[idx_nxt];
        anodo <= ~(N_DIGITS'(1) << idx_nxt);
      end
    end
  end
endmodule

// File: tb/tb_display_mux_7seg.sv
module tb_display_mux_7seg;
  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst, load, blink_en, lz_blank_en;
  logic [19:0] data_in;
  logic [6:0]  seven;
  logic [3:0]  anodo;
  logic [1:0]  digit_idx;

  int vectors = 0;
  int miscompares = 0;
  int t = 0;                  // edges since the last reset edge
  logic [4:0] ecode [N];      // expected shadow contents

  display_mux_7seg #(.N_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .blink_en(blink_en),
    .lz_blank_en(lz_blank_en), .seven(seven), .anodo(anodo), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rst) t <= 0; else t <= t + 1;

  function automatic logic [6:0] hex7(input logic [4:0] c);
    case (c)
      5'h00: return 7'b0000001;  5'h01: return 7'b1001111;
      5'h02: return 7'b0010010;  5'h03: return 7'b0000110;
      5'h04: return 7'b1001100;  5'h05: return 7'b0100100;
      5'h06: return 7'b0100000;  5'h07: return 7'b0001111;
      5'h08: return 7'b0000000;  5'h09: return 7'b0000100;
      5'h0A: return 7'b0001000;  5'h0B: return 7'b1100000;
      5'h0C: return 7'b0110001;  5'h0D: return 7'b1000010;
      5'h0E: return 7'b0110000;  5'h0F: return 7'b0111000;
      5'h10: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seven(input int tt);
    int d;
    logic z;
    if (tt % R == 0) return 7'b1111111;
    d = (tt / R) % N;
    if (lz_blank_en && d > 0) begin
      z = 1'b1;
      for (int j = d; j < N; j++) if (ecode[j] != 5'h00) z = 1'b0;
      if (z) return 7'b1111111;
    end
    if (blink_en && ((tt / B) % 2 == 1) && ecode[d] == 5'h10) return 7'b1111111;
    return hex7(ecode[d]);
  endfunction

  function automatic logic [3:0] exp_anodo(input int tt);
    if (tt % R == 0) return 4'b1111;
    return ~(4'b0001 << ((tt / R) % N));
  endfunction

  task automatic set_codes(input logic [19:0] d);
    for (int i = 0; i < N; i++) ecode[i] = d[5*i +: 5];
  endtask

  // Pulses load for one edge; returns at the negedge right after capture.
  task automatic do_load(input logic [19:0] d);
    @(negedge clk);
    data_in = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    set_codes(d);
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; blink_en = 1'b0; lz_blank_en = 1'b0; data_in = '0;
    set_codes({4{5'h1F}});
    @(negedge clk);
    @(negedge clk);
    vectors++; if (seven !== 7'b1111111) begin miscompares++; $display("FAIL reset seven got %b want 1111111", seven); end
    vectors++; if (anodo !== 4'b1111) begin miscompares++; $display("FAIL reset anodo got %b want 1111", anodo); end
    vectors++; if (digit_idx !== 2'd0) begin miscompares++; $display("FAIL reset digit_idx got %0d want 0", digit_idx); end
    rst = 1'b0;
  endtask

  task automatic test_scan;
    repeat (20) begin
      @(negedge clk);
      vectors++; if (digit_idx !== 2'((t / R) % N)) begin miscompares++; $display("FAIL scan idx t=%0d got %0d want %0d", t, digit_idx, (t / R) % N); end
      vectors++; if (anodo !== exp_anodo(t)) begin miscompares++; $display("FAIL scan anodo t=%0d got %b want %b", t, anodo, exp_anodo(t)); end
      vectors++; if (seven !== 7'b1111111) begin miscompares++; $display("FAIL scan seven t=%0d got %b want 1111111", t, seven); end
    end
  endtask

  task automatic test_load;
    do_load({5'h0F, 5'h0A, 5'h03, 5'h00});
    repeat (16) begin
      @(negedge clk);
      vectors++; if (seven !== exp_seven(t)) begin miscompares++; $display("FAIL load seven t=%0d got %b want %b", t, seven, exp_seven(t)); end
      vectors++; if (anodo !== exp_anodo(t)) begin miscompares++; $display("FAIL load anodo t=%0d got %b want %b", t, anodo, exp_anodo(t)); end
    end
    data_in = {5'h01, 5'h02, 5'h04, 5'h08};   // no load: display must hold
    repeat (16) begin
      @(negedge clk);
      vectors++; if (seven !== exp_seven(t)) begin miscompares++; $display("FAIL noload seven t=%0d got %b want %b", t, seven, exp_seven(t)); end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    data_in = {5'h01, 5'h01, 5'h01, 5'h01};
    load = 1'b1;
    @(negedge clk);
    data_in = {5'h0E, 5'h0D, 5'h0C, 5'h0B};
    @(negedge clk);
    load = 1'b0;
    set_codes({5'h0E, 5'h0D, 5'h0C, 5'h0B});
    repeat (16) begin
      @(negedge clk);
      vectors++; if (seven !== exp_seven(t)) begin miscompares++; $display("FAIL b2b seven t=%0d got %b want %b", t, seven, exp_seven(t)); end
    end
  endtask

  task automatic test_blink;
    // Digit 0 is scanned in blink phase 0, digit 2 in phase 1.
    do_load({5'h1F, 5'h10, 5'h1F, 5'h10});
    blink_en = 1'b1;
    repeat (32) begin
      @(negedge clk);
      vectors++; if (seven !== exp_seven(t)) begin miscompares++; $display("FAIL blink_on seven t=%0d got %b want %b", t, seven, exp_seven(t)); end
    end
    blink_en = 1'b0;
    @(negedge clk);
    repeat (16) begin
      @(negedge clk);
      vectors++; if (seven !== exp_seven(t)) begin miscompares++; $display("FAIL blink_off seven t=%0d got %b want %b", t, seven, exp_seven(t)); end
    end
  endtask

  task automatic test_lz_blank;
    lz_blank_en = 1'b1;
    do_load({5'h00, 5'h00, 5'h05, 5'h00});
    repeat (16) begin
      @(negedge clk);
      vectors++; if (seven !== exp_seven(t)) begin miscompares++; $display("FAIL lz_050 seven t=%0d got %b want %b", t, seven, exp_seven(t)); end
    end
    do_load({5'h00, 5'h00, 5'h00, 5'h00});
    repeat (16) begin
      @(negedge clk);
      vectors++; if (seven !== exp_seven(t)) begin miscompares++; $display("FAIL lz_zero seven t=%0d got %b want %b", t, seven, exp_seven(t)); end
    end
    do_load({5'h10, 5'h00, 5'h00, 5'h00});
    repeat (16) begin
      @(negedge clk);
      vectors++; if (seven !== exp_seven(t)) begin miscompares++; $display("FAIL lz_dash seven t=%0d got %b want %b", t, seven, exp_seven(t)); end
    end
    lz_blank_en = 1'b0;
    @(negedge clk);
    repeat (16) begin
      @(negedge clk);
      vectors++; if (seven !== exp_seven(t)) begin miscompares++; $display("FAIL lz_off seven t=%0d got %b want %b", t, seven, exp_seven(t)); end
    end
  endtask

  task automatic test_rst_mid;
    int guard;
    do_load({5'h01, 5'h02, 5'h03, 5'h04});
    guard = 0;
    while (t % R != 2 && guard < 10) begin @(negedge clk); guard++; end
    rst = 1'b1;
    load = 1'b1;
    data_in = {5'h07, 5'h07, 5'h07, 5'h07};
    set_codes({4{5'h1F}});
    @(negedge clk);
    vectors++; if (seven !== 7'b1111111) begin miscompares++; $display("FAIL rst_mid seven got %b want 1111111", seven); end
    vectors++; if (anodo !== 4'b1111) begin miscompares++; $display("FAIL rst_mid anodo got %b want 1111", anodo); end
    vectors++; if (digit_idx !== 2'd0) begin miscompares++; $display("FAIL rst_mid idx got %0d want 0", digit_idx); end
    rst = 1'b0;
    load = 1'b0;
    repeat (16) begin
      @(negedge clk);
      vectors++; if (seven !== exp_seven(t)) begin miscompares++; $display("FAIL rst_load seven t=%0d got %b want %b", t, seven, exp_seven(t)); end
      vectors++; if (anodo !== exp_anodo(t)) begin miscompares++; $display("FAIL rst_load anodo t=%0d got %b want %b", t, anodo, exp_anodo(t)); end
    end
  endtask

  task automatic test_code_sweep;
    logic [4:0] c;
    for (int i = 0; i < 32; i++) begin
      c = 5'(i);
      do_load({5'h1F, 5'h1F, 5'h1F, c});
      repeat (16) begin
        @(negedge clk);
        vectors++; if (seven !== exp_seven(t)) begin miscompares++; $display("FAIL sweep code=%h t=%0d got %b want %b", c, t, seven, exp_seven(t)); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_load;
    test_back_to_back;
    test_blink;
    test_lz_blank;
    test_rst_mid;
    test_code_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
